dmem_arbiter: RTL

- Two-requester arbiter/sequencer in front of the single-port 256-word data memory.
- Requester 0 is the CPU load/store stage; requester 1 is the program-loader/debug port.
- Serialises accesses with round-robin fairness, drives the memory's address/data/write-enable for exactly one cycle per access, and returns read data and a completion pulse to the winner.
- Out-of-range addresses are blocked and flagged with an error.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of a single-port data memory.
// Serves requester 0 (CPU) and requester 1 (loader/debug), one registered access every three cycles.
//
// state  | meaning
// IDLE   | arbitrate; capture the winner's command
// ACCESS | drive memory for one cycle; winner's gnt high
// RESP   | winner's done/err high; rdata updated for reads
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_winner, last_winner_nxt;
    logic              cmd_id, cmd_id_nxt;
    logic              cmd_we, cmd_we_nxt;
    logic [31:0]       cmd_addr, cmd_addr_nxt;
    logic [DATA_W-1:0] cmd_wdata, cmd_wdata_nxt;

    logic              gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, err0_nxt, err1_nxt;
    logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_din_nxt;
    logic              mem_we_nxt;

    logic              pick;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic              in_range;

    // Any nonzero bit above the memory address width is out of range; no wrap-around.
    assign in_range     = (cmd_addr[31:ADDR_W] == '0);
    assign pick         = (req0 && req1) ? ~last_winner : req1;
    assign sel_we       = pick ? we1 : we0;
    assign sel_addr     = pick ? addr1 : addr0;
    assign sel_wdata    = pick ? wdata1 : wdata0;
    assign sel_in_range = (sel_addr[31:ADDR_W] == '0);

    always_comb begin
        state_nxt       = state;
        last_winner_nxt = last_winner;
        cmd_id_nxt      = cmd_id;
        cmd_we_nxt      = cmd_we;
        cmd_addr_nxt    = cmd_addr;
        cmd_wdata_nxt   = cmd_wdata;
        gnt0_nxt        = 1'b0;
        gnt1_nxt        = 1'b0;
        done0_nxt       = 1'b0;
        done1_nxt       = 1'b0;
        err0_nxt        = 1'b0;
        err1_nxt        = 1'b0;
        rdata0_nxt      = rdata0;
        rdata1_nxt      = rdata1;
        mem_addr_nxt    = mem_addr;
        mem_din_nxt     = mem_din;
        mem_we_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt       = ACCESS;
                    last_winner_nxt = pick;
                    cmd_id_nxt      = pick;
                    cmd_we_nxt      = sel_we;
                    cmd_addr_nxt    = sel_addr;
                    cmd_wdata_nxt   = sel_wdata;
                    gnt0_nxt        = ~pick;
                    gnt1_nxt        = pick;
                    mem_addr_nxt    = sel_addr[ADDR_W-1:0];
                    mem_din_nxt     = sel_wdata;
                    mem_we_nxt      = sel_we && sel_in_range;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                done0_nxt = ~cmd_id;
                done1_nxt = cmd_id;
                err0_nxt  = ~cmd_id && !in_range;
                err1_nxt  = cmd_id && !in_range;
                if (!cmd_we) begin
                    if (cmd_id) rdata1_nxt = in_range ? mem_dout : '0;
                    else        rdata0_nxt = in_range ? mem_dout : '0;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            cmd_id      <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_we      <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_winner <= last_winner_nxt;
            cmd_id      <= cmd_id_nxt;
            cmd_we      <= cmd_we_nxt;
            cmd_addr    <= cmd_addr_nxt;
            cmd_wdata   <= cmd_wdata_nxt;
            gnt0        <= gnt0_nxt;
            gnt1        <= gnt1_nxt;
            done0       <= done0_nxt;
            done1       <= done1_nxt;
            err0        <= err0_nxt;
            err1        <= err1_nxt;
            rdata0      <= rdata0_nxt;
            rdata1      <= rdata1_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_din     <= mem_din_nxt;
            mem_we      <= mem_we_nxt;
        end
    end

endmodule
